shift_reg4: RTL



---
 rtl/shift_reg4.sv | 108 ++++++++++
 1 files changed

// File: rtl/shift_reg4.sv
// 4-bit universal operand shift register (hold / shift right / shift left / load)
// with a serial-capture sequencer that shifts in a full operand over WIDTH cycles.

module mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = (a & ~sel) | (b & sel);
endmodule

module dff_r (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end
endmodule

module shift_reg4 #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [3:0] d,
    input  logic       sin_r,
    input  logic       sin_l,
    input  logic       start,
    output logic [3:0] q,
    output logic       sout_r,
    output logic       sout_l,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        DONE    = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] count_q, count_d;
    logic [1:0] eff_mode;     // mode actually applied to the datapath this cycle
    logic [3:0] q_q, q_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        eff_mode = 2'b00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CAPTURE;
                    count_d = 2'b00;
                end else begin
                    eff_mode = mode;
                end
            end
            CAPTURE: begin
                eff_mode = 2'b01;
                count_d  = count_q + 2'b01;
                if (count_q == 2'(WIDTH - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;   // illegal code 11: q holds, recover to IDLE
        endcase
    end

    // Per bit: first mux picks shift direction, second picks hold/load, third picks shift vs hold/load.
    logic       is_shift;
    logic [3:0] sr_in, sl_in, shift_bit, lh_bit;

    assign is_shift = eff_mode[0] ^ eff_mode[1];
    assign sr_in    = {sin_r, q_q[3:1]};
    assign sl_in    = {q_q[2:0], sin_l};

    for (genvar i = 0; i < 4; i++) begin : g_bit
        mux2 u_dir   (.a(sr_in[i]),  .b(sl_in[i]),     .sel(eff_mode[1]), .y(shift_bit[i]));
        mux2 u_ldh   (.a(q_q[i]),    .b(d[i]),         .sel(eff_mode[1]), .y(lh_bit[i]));
        mux2 u_sel   (.a(lh_bit[i]), .b(shift_bit[i]), .sel(is_shift),    .y(q_d[i]));
        dff_r u_ff   (.clk(clk), .rst_n(rst_n), .d(q_d[i]), .q(q_q[i]));
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[3];
    assign busy   = (state_q == CAPTURE);
    assign done   = (state_q == DONE);

endmodule
